load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have parameter DM_WORDS, default 1000, giving the number of 32-bit words in the data memory behind it.
REQ-002 The block SHALL have port clk  in  1  clock; all state updates on rising edge.
REQ-003 The block SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-004 The block SHALL have port req_valid  in  1  pipeline presents a memory op.
REQ-005 The block SHALL have port req_ready  out  1  high only in IDLE; the pipeline stalls while low.
REQ-006 The block SHALL have ports is_load, is_store  in  1 each  op kind.
REQ-007 The block SHALL have port funct3  in  3  RV32I width/sign code.
REQ-008 The block SHALL have ports addr, store_data  in  32 each  byte address, store operand.
REQ-009 The block SHALL have port resp_valid  out  1  one-cycle completion pulse.
REQ-010 The block SHALL have port load_data  out  32  extended load result, valid with resp_valid.
REQ-011 The block SHALL have port err  out  1  access fault, valid with resp_valid.
REQ-012 The block SHALL have ports dm_en  out  1, dm_addr  out  32, dm_wdata  out  32, dm_rdata  in  32  word-wide memory side (asynchronous read, synchronous write).

Function
REQ-013 The block SHALL accept a request when req_valid and req_ready are both high, latching op, funct3, addr and store_data.
REQ-014 The FSM SHALL have states IDLE, EXEC, MERGE, RESP.
REQ-015 Transitions SHALL be: IDLE->EXEC on a legal accept; IDLE->RESP on an illegal accept with err set; EXEC->MERGE for SB/SH; EXEC->RESP otherwise; MERGE->RESP; RESP->IDLE.
REQ-016 Legal funct3 values SHALL be: loads 000/001/010/100/101; stores 000/001/010. Any other value is illegal.
REQ-017 A request SHALL be illegal if both is_load and is_store are high, or both are low.
REQ-018 A request SHALL be illegal if misaligned: halfword with addr[0]=1, or word with addr[1:0]!=0.
REQ-019 A request SHALL be illegal if out of range: addr[31:2] >= DM_WORDS.
REQ-020 An illegal access SHALL never assert dm_en.
REQ-021 dm_addr SHALL equal the latched address with bits [1:0] forced to 0 in every non-IDLE state, and 0 in IDLE.
REQ-022 For loads in EXEC, the selected byte/halfword of dm_rdata (lane = addr[1:0]) SHALL be registered into load_data: sign-extended for 000/001, zero-extended for 100/101, the full word for 010.
REQ-023 For SW in EXEC, the block SHALL assert dm_en with dm_wdata = store_data.
REQ-024 For SB/SH in EXEC, the block SHALL register dm_rdata; in MERGE it SHALL assert dm_en with that word, only the addressed lane replaced by store_data[7:0] or [15:0].
REQ-025 dm_en SHALL be high only in those two cases; dm_wdata SHALL be 0 whenever dm_en is low.
REQ-026 Latency from the accept cycle N: resp_valid SHALL assert at N+2 for load/SW, N+3 for SB/SH, and N+1 for an illegal access.
REQ-027 load_data SHALL be 0 for stores and for errors; err SHALL be 0 on success.
REQ-028 req_valid arriving in non-IDLE states SHALL be ignored; back-to-back requests SHALL be accepted from the cycle after RESP.

Reset
REQ-029 While rst is high, the state SHALL go to IDLE and all latched registers SHALL clear.
REQ-030 While rst is high, dm_en SHALL be forced low combinationally, so a reset during EXEC or MERGE aborts with no memory write.
REQ-031 Output values during and after reset SHALL be: req_ready=1 after the reset cycle, resp_valid=0, err=0, load_data=0, dm_en=0, dm_addr=0, dm_wdata=0.
REQ-032 A request presented in the reset cycle SHALL be dropped.

Structure
REQ-033 The shared package lsu_pkg SHALL hold the funct3 encodings enum, the lsu_state_t enum and the DM_WORDS default.
REQ-034 Lane extraction/extension and lane merge SHALL live in one combinational sub-module, lsu_lane.
REQ-035 The FSM, latches and legality check SHALL stay in load_store_unit.

Verification
REQ-036 With mem[4]=0x8899AABB, LB at 0x12 -> resp at N+2, load_data=0xFFFFFF99; LBU at 0x12 -> 0x00000099.
REQ-037 With mem[4]=0x8899AABB, SH 0x1234 at 0x12 -> a single dm_en pulse at N+2 with dm_wdata=0x1234AABB; resp at N+3.
REQ-038 LW at 0x11 or SW at 0x13 -> resp at N+1 with err=1; dm_en never asserts.
REQ-039 LW at 4*DM_WORDS -> err=1; SW at 0x0, data 0xDEADBEEF -> dm_en at N+1, then LW at 0x0 returns 0xDEADBEEF.
REQ-040 Assert rst during MERGE of an SB -> dm_en=0 in that cycle, mem unchanged, req_ready=1 the cycle after.
REQ-041 Hold req_valid high for 3 consecutive LW ops -> exactly 3 accepts, one every 3 cycles, with responses in order.

Source files
------------

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared encodings, FSM states and defaults for the load/store unit
package lsu_pkg;
    localparam int DM_WORDS_DEFAULT = 1000;

    typedef enum logic [2:0] {
        F3_B  = 3'b000,
        F3_H  = 3'b001,
        F3_W  = 3'b010,
        F3_BU = 3'b100,
        F3_HU = 3'b101
    } funct3_e;

    typedef enum logic [1:0] {IDLE, EXEC, MERGE, RESP} lsu_state_t;

    function automatic logic f3_legal(input logic ld, input logic [2:0] f);
        return ld ? (f inside {F3_B, F3_H, F3_W, F3_BU, F3_HU}) : (f inside {F3_B, F3_H, F3_W});
    endfunction
endpackage

// File: rtl/lsu_lane.sv
// lsu_lane: byte/halfword lane extraction with extension, and lane merge for sub-word stores
module lsu_lane (
    input  logic [31:0] rdata_i,
    input  logic [31:0] wdata_i,
    input  logic [1:0]  lane_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] ext_o,
    output logic [31:0] merged_o
);
    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        b = rdata_i[{lane_i, 3'b000} +: 8];
        h = rdata_i[{lane_i[1], 4'b0000} +: 16];
        ext_o = funct3_i[1:0] == 2'b00 ? {{24{b[7] & ~funct3_i[2]}}, b}
              : funct3_i[1:0] == 2'b01 ? {{16{h[15] & ~funct3_i[2]}}, h} : rdata_i;
        merged_o = rdata_i;
        if (funct3_i[1:0] == 2'b00) merged_o[{lane_i, 3'b000} +: 8] = wdata_i[7:0];
        else if (funct3_i[1:0] == 2'b01) merged_o[{lane_i[1], 4'b0000} +: 16] = wdata_i[15:0];
        else merged_o = wdata_i;
    end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding RV32I load/store engine in front of a word-wide data memory;
// sub-word stores are done as read-modify-write.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int DM_WORDS = DM_WORDS_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        is_load,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        resp_valid,
    output logic [31:0] load_data,
    output logic        err,
    output logic        dm_en,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    input  logic [31:0] dm_rdata
);
    lsu_state_t  state_q, state_d;
    logic        store_q, err_q;
    logic [2:0]  f3_q;
    logic [31:0] addr_q, sdata_q, word_q, load_q;
    logic [31:0] ext, merged;
    logic        accept, legal, misaligned, in_range;

    assign misaligned = (funct3[1:0] == 2'b01 && addr[0]) || (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00);
    assign in_range   = {2'b00, addr[31:2]} < $unsigned(DM_WORDS);
    assign legal      = (is_load ^ is_store) && f3_legal(is_load, funct3) && !misaligned && in_range;
    assign accept     = req_valid && req_ready;

    lsu_lane u_lane (
        .rdata_i  (state_q == MERGE ? word_q : dm_rdata),
        .wdata_i  (sdata_q),
        .lane_i   (addr_q[1:0]),
        .funct3_i (f3_q),
        .ext_o    (ext),
        .merged_o (merged)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = legal ? EXEC : RESP;
            EXEC:    state_d = (store_q && f3_q[1:0] != 2'b10) ? MERGE : RESP;
            MERGE:   state_d = RESP;
            default: state_d = IDLE;
        endcase
    end

    // Reset gates every output so an in-flight write is aborted in the reset cycle itself.
    always_comb begin
        req_ready  = !rst && state_q == IDLE;
        resp_valid = !rst && state_q == RESP;
        err        = resp_valid && err_q;
        load_data  = resp_valid ? load_q : '0;
        dm_addr    = (!rst && state_q != IDLE) ? {addr_q[31:2], 2'b00} : '0;
        dm_en      = !rst && store_q && (state_q == MERGE || (state_q == EXEC && f3_q[1:0] == 2'b10));
        dm_wdata   = !dm_en ? '0 : state_q == MERGE ? merged : sdata_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            store_q <= 1'b0;
            err_q   <= 1'b0;
            f3_q    <= '0;
            addr_q  <= '0;
            sdata_q <= '0;
            word_q  <= '0;
            load_q  <= '0;
        end else begin
            if (accept) begin
                store_q <= is_store;
                err_q   <= !legal;
                f3_q    <= funct3;
                addr_q  <= addr;
                sdata_q <= store_data;
                load_q  <= '0;
            end
            if (state_q == EXEC) word_q <= dm_rdata;
            if (state_q == EXEC && !store_q) load_q <= ext;
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: randomized scoreboard bench against a byte-level reference memory model
module tb_load_store_unit;
    localparam int DW = 1000;

    logic        clk = 0, rst = 1, req_valid = 0, is_load = 0, is_store = 0;
    logic        req_ready, resp_valid, err, dm_en;
    logic [2:0]  funct3 = 0;
    logic [31:0] addr = 0, store_data = 0;
    logic [31:0] load_data, dm_addr, dm_wdata, dm_rdata;
    logic [31:0] mem [DW];
    logic [31:0] ref_mem [DW];
    logic        load_mem = 0;
    int          cyc = 0, cnt = 0, fails = 0, nw = 0;

    typedef struct {
        int        n;
        int        lat;
        bit        err;
        bit [31:0] data;
        int        nw;
        int        wlat;
        bit [31:0] wdata;
    } exp_t;
    exp_t q[$];
    exp_t me;

    load_store_unit #(.DM_WORDS(DW)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .is_load(is_load), .is_store(is_store), .funct3(funct3), .addr(addr),
        .store_data(store_data), .resp_valid(resp_valid), .load_data(load_data), .err(err),
        .dm_en(dm_en), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata)
    );

    always #5 clk = ~clk;

    assign dm_rdata = (dm_addr[31:2] < DW) ? mem[dm_addr[31:2]] : 32'h0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (load_mem) for (int i = 0; i < DW; i++) mem[i] <= ref_mem[i];
        else if (dm_en && dm_addr[31:2] < DW) mem[dm_addr[31:2]] <= dm_wdata;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        cnt++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (dm_en) begin
            chk("write pending", 32'(q.size() != 0), 1);
            if (q.size() != 0) begin
                chk("write data", dm_wdata, q[0].wdata);
                chk("write latency", 32'(cyc - q[0].n), 32'(q[0].wlat));
                nw++;
            end
        end
        if (resp_valid) begin
            chk("resp pending", 32'(q.size() != 0), 1);
            if (q.size() != 0) begin
                me = q.pop_front();
                chk("load_data", load_data, me.data);
                chk("err", 32'(err), 32'(me.err));
                chk("resp latency", 32'(cyc - me.n), 32'(me.lat));
                chk("write count", 32'(nw), 32'(me.nw));
            end
            nw = 0;
        end
    end

    task automatic issue(input bit ld, input bit st, input bit [2:0] f, input bit [31:0] a,
                         input bit [31:0] d, output int n);
        exp_t e;
        int w, sz, sh;
        bit ok;
        bit [31:0] wd, m;
        @(posedge clk); #1;
        req_valid = 1; is_load = ld; is_store = st; funct3 = f; addr = a; store_data = d;
        w = 0;
        @(negedge clk);
        while (!req_ready && w < 20) begin @(negedge clk); w++; end
        if (!req_ready) begin
            chk("accept timeout", 32'(req_ready), 1);
            n = -1;
            return;
        end
        n  = cyc;
        sz = (f[1:0] == 0) ? 1 : (f[1:0] == 1) ? 2 : 4;
        sh = 8 * int'(a % 4);
        ok = (ld != st) && (ld ? (f inside {0, 1, 2, 4, 5}) : (f inside {0, 1, 2}))
             && (a % sz == 0) && (a / 4 < DW);
        e = '{n: n, lat: 1, err: 1, data: 0, nw: 0, wlat: 0, wdata: 0};
        if (ok) begin
            e.err = 0;
            wd = ref_mem[a / 4];
            if (ld) begin
                e.lat = 2;
                if (sz == 4) e.data = wd;
                else begin
                    e.data = (wd >> sh) & ((sz == 1) ? 32'hFF : 32'hFFFF);
                    if (!f[2] && e.data[8 * sz - 1]) e.data |= (sz == 1) ? 32'hFFFFFF00 : 32'hFFFF0000;
                end
            end else begin
                m  = (sz == 4) ? 32'hFFFFFFFF : (((sz == 1) ? 32'hFF : 32'hFFFF) << sh);
                wd = (wd & ~m) | ((d << sh) & m);
                ref_mem[a / 4] = wd;
                e.lat   = (sz == 4) ? 2 : 3;
                e.nw    = 1;
                e.wlat  = e.lat - 1;
                e.wdata = wd;
            end
        end
        q.push_back(e);
    endtask

    task automatic idle(input int k);
        @(posedge clk); #1;
        req_valid = 0;
        repeat (k) @(posedge clk);
    endtask

    initial begin
        int n, n1, n2, n3, w, r;
        bit ld, st;
        bit [2:0] f;
        bit [31:0] a, old;
        for (int i = 0; i < DW; i++) ref_mem[i] = $urandom;
        ref_mem[4] = 32'h8899AABB;
        load_mem = 1;
        @(posedge clk); #1;
        load_mem = 0;
        req_valid = 1; is_load = 1; funct3 = 3'b010; addr = 32'h0;
        @(negedge clk);
        chk("reset resp_valid", 32'(resp_valid), 0);
        chk("reset dm_en", 32'(dm_en), 0);
        chk("reset dm_addr", dm_addr, 0);
        chk("reset dm_wdata", dm_wdata, 0);
        chk("reset load_data", load_data, 0);
        chk("reset err", 32'(err), 0);
        @(posedge clk); #1;
        rst = 0; req_valid = 0;
        @(negedge clk);
        chk("ready after reset", 32'(req_ready), 1);

        issue(1, 0, 3'b000, 32'h12, 0, n);
        issue(1, 0, 3'b100, 32'h12, 0, n);
        issue(0, 1, 3'b001, 32'h12, 32'h1234, n);
        issue(1, 0, 3'b010, 32'h10, 0, n);
        issue(1, 0, 3'b010, 32'h11, 0, n);
        issue(0, 1, 3'b010, 32'h13, 0, n);
        issue(1, 0, 3'b010, 4 * DW, 0, n);
        issue(0, 1, 3'b010, 32'h0, 32'hDEADBEEF, n);
        issue(1, 0, 3'b010, 32'h0, 0, n);
        idle(3);

        old = ref_mem[8];
        @(posedge clk); #1;
        req_valid = 1; is_load = 0; is_store = 1; funct3 = 3'b000; addr = 32'h21; store_data = 32'h5A;
        @(negedge clk);
        chk("rst-test accept", 32'(req_ready), 1);
        @(posedge clk); #1;
        req_valid = 0;
        @(posedge clk); #1;
        rst = 1;
        @(negedge clk);
        chk("rst in MERGE dm_en", 32'(dm_en), 0);
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        chk("ready after abort", 32'(req_ready), 1);
        chk("mem after abort", mem[8], old);

        issue(1, 0, 3'b010, 32'h04, 0, n1);
        issue(1, 0, 3'b010, 32'h08, 0, n2);
        issue(1, 0, 3'b010, 32'h0C, 0, n3);
        chk("b2b spacing 1", 32'(n2 - n1), 3);
        chk("b2b spacing 2", 32'(n3 - n2), 3);
        idle(2);

        for (int i = 0; i < 300; i++) begin
            r  = $urandom_range(0, 9);
            ld = (r < 4) || (r == 8);
            st = (r >= 4 && r < 8) || (r == 8);
            f  = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) != 0) f = 3'($urandom_range(0, 2));
            if (ld && $urandom_range(0, 3) == 0) f[2] = 1'b1;
            a = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 127));
            issue(ld, st, f, a, $urandom, n);
            if ($urandom_range(0, 2) == 0) idle($urandom_range(0, 3));
        end
        idle(1);

        w = 0;
        while (q.size() > 0 && w < 20) begin @(negedge clk); w++; end
        chk("drain", 32'(q.size()), 0);
        for (int i = 0; i < 40; i++) chk("mem word", mem[i], ref_mem[i]);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cnt, fails);
        $finish;
    end
endmodule
